// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD <-> binary conversion blocks.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam int         BCD_DIGITS     = 4;
    localparam int         BCD_BITS       = 4 * BCD_DIGITS;
    localparam logic [3:0] BCD_DIGIT_MAX  = 4'd9;
    localparam logic [3:0] DABBLE_THRESH  = 4'd8;
    localparam logic [3:0] DABBLE_ADJ     = 4'd3;
    // Add-3 threshold used by the forward binary-to-BCD display converter.
    localparam logic [3:0] FWD_ADD3_THRESH = 4'd5;

    // True when every packed digit is a legal decimal digit.
    function automatic logic digits_valid(input logic [BCD_BITS-1:0] digits);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (digits[4*i +: 4] > BCD_DIGIT_MAX) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_digit_correct.sv
// Reverse double-dabble digit fix-up: a digit that reached 8 or more after
// the right shift had a 10 folded into it, so pull it back down by 3.
module bcd_digit_correct
    import bcd_pkg::*;
(
    input  logic [3:0] raw,
    output logic [3:0] adjusted
);

    assign adjusted = (raw >= DABBLE_THRESH) ? (raw - DABBLE_ADJ) : raw;

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential four-digit BCD to binary converter (reverse double-dabble).
// One bit is shifted out of the BCD register into the accumulator per cycle;
// BIN_WIDTH must be at least 14 so that 9999 fits.
module bcd_to_binary_seq
    import bcd_pkg::*;
#(
    parameter int BIN_WIDTH = 14
)
(
    input  logic                 Clock,
    input  logic                 Reset_n,
    input  logic                 Start,
    input  logic [3:0]           Thousands,
    input  logic [3:0]           Hundreds,
    input  logic [3:0]           Tens,
    input  logic [3:0]           Ones,
    output logic [BIN_WIDTH-1:0] Binary,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Error
);

    localparam int            CW   = $clog2(BIN_WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(BIN_WIDTH - 1);

    state_t                state;
    state_t                nextstate;
    logic [BCD_BITS-1:0]   bcd;
    logic [BIN_WIDTH-1:0]  acc;
    logic [CW-1:0]         count;
    logic                  errflag;

    logic [BCD_BITS-1:0]   digits;
    logic                  digitsok;
    logic [BCD_BITS-1:0]   shifted;
    logic [BCD_BITS-1:0]   corrected;
    logic [BIN_WIDTH-1:0]  accnext;

    assign digits   = {Thousands, Hundreds, Tens, Ones};
    assign digitsok = digits_valid(digits);

    // The BCD LSB falls into the accumulator MSB; a zero enters the BCD MSB.
    assign shifted  = {1'b0, bcd[BCD_BITS-1:1]};
    assign accnext  = {bcd[0], acc[BIN_WIDTH-1:1]};

    for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_fix
        bcd_digit_correct u_fix (
            .raw      (shifted[4*i +: 4]),
            .adjusted (corrected[4*i +: 4])
        );
    end

    assign Busy = (state != IDLE);

    // State register.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= nextstate;
        end
    end

    // Next-state logic: invalid digits skip straight to FINISH.
    always_comb begin
        nextstate = state;
        case (state)
            IDLE: begin
                if (Start) begin
                    nextstate = digitsok ? SHIFT : FINISH;
                end
            end
            SHIFT: begin
                if (count == LAST) begin
                    nextstate = FINISH;
                end
            end
            FINISH: begin
                nextstate = IDLE;
            end
            default: begin
                nextstate = IDLE;
            end
        endcase
    end

    // Datapath: latch digits, shift/correct, then publish the result.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            bcd     <= '0;
            acc     <= '0;
            count   <= '0;
            errflag <= 1'b0;
            Binary  <= '0;
            Done    <= 1'b0;
            Error   <= 1'b0;
        end else begin
            Done  <= 1'b0;
            Error <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        if (digitsok) begin
                            bcd     <= digits;
                            acc     <= '0;
                            count   <= '0;
                            errflag <= 1'b0;
                        end else begin
                            errflag <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    bcd   <= corrected;
                    acc   <= accnext;
                    count <= count + 1'b1;
                end
                FINISH: begin
                    Binary <= errflag ? '0 : acc;
                    Done   <= 1'b1;
                    Error  <= errflag;
                end
                default: begin
                    errflag <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Self-checking bench for bcd_to_binary_seq: fixed vector table, hand-written
// corner sequences and randomized digits against a decimal reference model.
module tb_bcd_to_binary_seq;

    localparam int BIN_WIDTH = 14;
    localparam int NVEC      = 6;

    logic                 Clock = 1'b0;
    logic                 Reset_n;
    logic                 Start;
    logic [3:0]           Thousands, Hundreds, Tens, Ones;
    logic [BIN_WIDTH-1:0] Binary;
    logic                 Busy, Done, Error;

    int compared   = 0;
    int mismatched = 0;
    int cycle      = 0;

    typedef struct {
        logic [3:0] th, h, t, o;
        int         expBin;
        bit         expErr;
        int         expLat;
    } vec_t;

    vec_t vecs [NVEC];

    bcd_to_binary_seq #(.BIN_WIDTH(BIN_WIDTH)) dut (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .Start     (Start),
        .Thousands (Thousands),
        .Hundreds  (Hundreds),
        .Tens      (Tens),
        .Ones      (Ones),
        .Binary    (Binary),
        .Busy      (Busy),
        .Done      (Done),
        .Error     (Error)
    );

    // Free-running clock.
    always #5 Clock = ~Clock;

    // Absolute cycle counter used to measure spacing between Done pulses.
    always @(posedge Clock) cycle <= cycle + 1;

    // Decimal reference: value is plain positional arithmetic.
    function automatic void refModel(input logic [3:0] th, h, t, o,
                                     output int bin, output bit err, output int lat);
        err = (th > 9) || (h > 9) || (t > 9) || (o > 9);
        bin = err ? 0 : int'(th) * 1000 + int'(h) * 100 + int'(t) * 10 + int'(o);
        lat = err ? 1 : BIN_WIDTH + 1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Pulse Start with the given digits, then wait (bounded) for Done.
    // restartAt >= 0 re-asserts Start with 9999 that many cycles in.
    task automatic applyStimulus(input logic [3:0] th, h, t, o, input int restartAt,
                                 output int lat, output int busyCycles,
                                 output bit held, output int doneAt);
        logic [BIN_WIDTH-1:0] prev;
        prev = Binary;
        {Thousands, Hundreds, Tens, Ones} = {th, h, t, o};
        Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        {Thousands, Hundreds, Tens, Ones} = 16'($urandom);
        lat        = 0;
        busyCycles = 0;
        held       = 1'b1;
        while (!Done && lat < 40) begin
            if (Busy) busyCycles++;
            if (Binary !== prev) held = 1'b0;
            Start = (lat == restartAt);
            if (lat == restartAt) {Thousands, Hundreds, Tens, Ones} = 16'h9999;
            @(posedge Clock); #1;
            lat++;
        end
        Start  = 1'b0;
        doneAt = cycle;
    endtask

    task automatic verify(input string name, input int expBin, input bit expErr,
                          input int expLat, input int lat, input int busyCycles,
                          input bit held);
        checkOutput({name, " latency"}, 32'(lat), 32'(expLat));
        checkOutput({name, " binary"}, 32'(Binary), 32'(expBin));
        checkOutput({name, " error"}, 32'(Error), 32'(expErr));
        checkOutput({name, " busy at done"}, 32'(Busy), 32'd0);
        checkOutput({name, " busy cycles"}, 32'(busyCycles), 32'(expLat));
        checkOutput({name, " binary held"}, 32'(held), 32'd1);
        if (!expErr) checkOutput({name, " bcd drained"}, 32'(dut.bcd), 32'd0);
    endtask

    task automatic countDones(input int n, output int dones);
        dones = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge Clock); #1;
            if (Done) dones++;
        end
    endtask

    initial begin
        int lat, busyCycles, doneAt, prevDone, dones, expBin, expLat;
        bit held, expErr;
        logic [3:0] d [4];

        vecs[0] = '{4'd9, 4'd9, 4'd9, 4'd9, 9999, 1'b0, 15};
        vecs[1] = '{4'd0, 4'd0, 4'd0, 4'd0, 0,    1'b0, 15};
        vecs[2] = '{4'd1, 4'd2, 4'd3, 4'd4, 1234, 1'b0, 15};
        vecs[3] = '{4'd0, 4'd0, 4'd0, 4'd5, 5,    1'b0, 15};
        vecs[4] = '{4'd0, 4'd0, 4'd8, 4'd0, 80,   1'b0, 15};
        vecs[5] = '{4'd0, 4'd0, 4'hA, 4'd0, 0,    1'b1, 1};

        // Reset state.
        Reset_n = 1'b0;
        Start   = 1'b0;
        {Thousands, Hundreds, Tens, Ones} = 16'h0000;
        repeat (3) @(posedge Clock);
        #1;
        checkOutput("reset binary", 32'(Binary), 32'd0);
        checkOutput("reset busy", 32'(Busy), 32'd0);
        checkOutput("reset done", 32'(Done), 32'd0);
        checkOutput("reset error", 32'(Error), 32'd0);
        @(negedge Clock) Reset_n = 1'b1;
        @(posedge Clock); #1;

        // Table vectors, issued back-to-back.
        prevDone = 0;
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].th, vecs[i].h, vecs[i].t, vecs[i].o, -1,
                          lat, busyCycles, held, doneAt);
            verify($sformatf("vec%0d", i), vecs[i].expBin, vecs[i].expErr,
                   vecs[i].expLat, lat, busyCycles, held);
            if (i == 2) checkOutput("back-to-back spacing", 32'(doneAt - prevDone), 32'd16);
            prevDone = doneAt;
        end
        @(posedge Clock); #1;
        checkOutput("busy after error", 32'(Busy), 32'd0);

        // Start re-pulsed mid-conversion must be ignored.
        applyStimulus(4'd1, 4'd2, 4'd3, 4'd4, 4, lat, busyCycles, held, doneAt);
        verify("restart ignored", 1234, 1'b0, 15, lat, busyCycles, held);
        countDones(20, dones);
        checkOutput("restart single done", 32'(dones), 32'd0);

        // Reset in the middle of a conversion.
        {Thousands, Hundreds, Tens, Ones} = 16'h1234;
        Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        repeat (6) begin
            @(posedge Clock); #1;
        end
        Reset_n = 1'b0;
        #1;
        checkOutput("midreset binary", 32'(Binary), 32'd0);
        checkOutput("midreset busy", 32'(Busy), 32'd0);
        checkOutput("midreset done", 32'(Done), 32'd0);
        @(negedge Clock) Reset_n = 1'b1;
        countDones(20, dones);
        checkOutput("midreset no done", 32'(dones), 32'd0);
        applyStimulus(4'd0, 4'd4, 4'd2, 4'd0, -1, lat, busyCycles, held, doneAt);
        verify("after reset 420", 420, 1'b0, 15, lat, busyCycles, held);

        // Randomized digits against the decimal model.
        for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < 4; k++) begin
                d[k] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                    : 4'($urandom_range(0, 9));
            end
            refModel(d[0], d[1], d[2], d[3], expBin, expErr, expLat);
            applyStimulus(d[0], d[1], d[2], d[3], -1, lat, busyCycles, held, doneAt);
            verify($sformatf("rand%0d %h%h%h%h", r, d[0], d[1], d[2], d[3]),
                   expBin, expErr, expLat, lat, busyCycles, held);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/bcd_to_binary_seq.md
Name: bcd_to_binary_seq

Overview:
- Sequential BCD-to-binary converter; the inverse of the binary-to-BCD path used by the frequency-counter display logic.
- Accepts four packed BCD digits (thousands..ones) on a Start strobe and converts them with a reverse double-dabble algorithm: shift right one bit per cycle, then subtract 3 from any digit >= 8.
- Produces a registered binary result with a Done pulse.
- Used to turn keypad/preset decimal entries into binary compare values for the counter.

Parameters:
- BIN_WIDTH, 14, width of the Binary output and the number of shift iterations. Must be >= 14 (9999 needs 14 bits). Result is zero-extended when larger.

Ports:
- Clock  in  1  system clock, rising edge
- Reset_n  in  1  asynchronous active-low reset
- Start  in  1  request conversion; sampled only in IDLE
- Thousands  in  4  BCD digit 3
- Hundreds  in  4  BCD digit 2
- Tens  in  4  BCD digit 1
- Ones  in  4  BCD digit 0
- Binary  out  BIN_WIDTH  converted value, registered, held until the next conversion completes
- Busy  out  1  high while not in IDLE
- Done  out  1  one-cycle pulse, result valid
- Error  out  1  one-cycle pulse with Done when any input digit > 9

Behaviour:
- Reset (async, Reset_n=0): state=IDLE; Binary=0, Busy=0, Done=0, Error=0; internal BCD shift register and count cleared. Reset mid-conversion aborts with no Done.
- States: IDLE, SHIFT, FINISH.
- IDLE, Start=1, all digits <= 9:
  - latch {Thousands,Hundreds,Tens,Ones} into a 16-bit BCD register;
  - clear the BIN_WIDTH-bit accumulator and count;
  - go to SHIFT.
- IDLE, Start=1, any digit > 9:
  - go to FINISH with an error flag set; no shifting.
- SHIFT, each cycle:
  - shift the concatenation {bcd, acc} right by 1; bcd LSB enters acc MSB, zero enters bcd MSB;
  - then each 4-bit bcd digit >= 8 has 3 subtracted (4-bit arithmetic, no borrow across digits);
  - count increments.
  - After BIN_WIDTH shift cycles, go to FINISH.
- FINISH (one cycle):
  - Binary <= acc, or 0 when the error flag is set;
  - Done=1; Error=error flag;
  - go to IDLE.
- Done/Error are registered outputs: high during the cycle after the FINISH-state clock edge.
- Latency: Start sampled at edge 0 → Done high after edge BIN_WIDTH+1 (15 cycles at default). Error case: Done high after edge 1.
- Start is ignored while in SHIFT or FINISH; input digits may change freely after the Start edge.
- Back-to-back: Start may be asserted in the cycle Done is high (state is IDLE), giving throughput of one conversion per BIN_WIDTH+2 cycles.
- Binary retains the previous result while Busy; it updates only in FINISH.
- Busy is high in SHIFT and FINISH, low in IDLE.
- Invariant: after BIN_WIDTH shifts the bcd register is all zeros for valid input. Verification asserts this.

Decomposition:
- Shared package bcd_pkg:
  - state enum {IDLE, SHIFT, FINISH};
  - constants BCD_DIGIT_MAX=9, DABBLE_THRESH=8, DABBLE_ADJ=3, BCD_DIGITS=4;
  - the existing forward converter's add-3 threshold (5) belongs here too.
- One sub-module, bcd_digit_correct: combinational 4-bit in/out, out = (in >= 8) ? in-3 : in. Instantiated four times on the post-shift bcd register.

Test Plan:
- Reset, then Start with digits 9,9,9,9 → Done after exactly 15 cycles, Binary=9999 (0x270F), Error=0, Busy high for cycles 1..15.
- Digits 0,0,0,0 → Binary=0; then digits 1,2,3,4 back-to-back (Start during Done cycle) → Binary=1234, second Done 16 cycles after the first.
- Digits 0,0,0,5 then 0,0,8,0 → Binary=5 then 80; checks single-digit correction at the boundary values 5 and 8.
- Tens=4'hA, others 0 → Done and Error high one cycle after Start, Binary=0, Busy low afterwards.
- Start pulsed again at cycle 5 of a 1234 conversion with digits 9,9,9,9 → ignored, result still 1234, only one Done.
- Reset_n low at cycle 7 of a conversion → outputs immediately 0, state IDLE, no Done; a new Start of 0,4,2,0 yields 420.
